// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit and its neighbours: branch predictor lookup,
// memory controller fetch port, instruction queue push port and ROB redirect.
interface instr_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] if_to_pr_PC;
  logic                  pr_to_if_prediction;

  logic                  if_to_mc_valid;
  logic [ADDR_WIDTH-1:0] if_to_mc_PC;
  logic                  mc_to_if_ready;
  logic [INST_WIDTH-1:0] mc_to_if_inst;

  logic                  iq_full;
  logic                  if_to_iq_valid;
  logic [INST_WIDTH-1:0] if_to_iq_inst;
  logic [ADDR_WIDTH-1:0] if_to_iq_PC;
  logic                  if_to_iq_pred_taken;

  logic                  rob_to_if_flush;
  logic [ADDR_WIDTH-1:0] rob_to_if_target;

  modport master (
    output if_to_pr_PC, if_to_mc_valid, if_to_mc_PC,
           if_to_iq_valid, if_to_iq_inst, if_to_iq_PC, if_to_iq_pred_taken,
    input  pr_to_if_prediction, mc_to_if_ready, mc_to_if_inst, iq_full,
           rob_to_if_flush, rob_to_if_target
  );

  modport slave (
    input  if_to_pr_PC, if_to_mc_valid, if_to_mc_PC,
           if_to_iq_valid, if_to_iq_inst, if_to_iq_PC, if_to_iq_pred_taken,
    output pr_to_if_prediction, mc_to_if_ready, mc_to_if_inst, iq_full,
           rob_to_if_flush, rob_to_if_target
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch-side PC generator: requests instructions, predicts the next PC from
// JAL/branch immediates and the predictor, and pushes results into the IQ.
module instr_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {FETCH, HOLD, REDIRECT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] hold_next_q, hold_next_d;
  logic                  iq_valid_q, iq_valid_d;
  logic [INST_WIDTH-1:0] iq_inst_q, iq_inst_d;
  logic [ADDR_WIDTH-1:0] iq_pc_q, iq_pc_d;
  logic                  iq_pred_q, iq_pred_d;

  logic [6:0]            opcode;
  logic [ADDR_WIDTH-1:0] imm_b, imm_j;
  logic                  fetch_pred;
  logic [ADDR_WIDTH-1:0] fetch_next;

  assign opcode = bus.mc_to_if_inst[6:0];
  assign imm_b  = {{(ADDR_WIDTH-12){bus.mc_to_if_inst[31]}}, bus.mc_to_if_inst[7],
                   bus.mc_to_if_inst[30:25], bus.mc_to_if_inst[11:8], 1'b0};
  assign imm_j  = {{(ADDR_WIDTH-20){bus.mc_to_if_inst[31]}}, bus.mc_to_if_inst[19:12],
                   bus.mc_to_if_inst[20], bus.mc_to_if_inst[30:21], 1'b0};

  always_comb begin
    fetch_pred = 1'b0;
    fetch_next = pc_q + ADDR_WIDTH'(4);
    case (opcode)
      7'b1101111: begin
        fetch_pred = 1'b1;
        fetch_next = pc_q + imm_j;
      end
      7'b1100011: begin
        fetch_pred = bus.pr_to_if_prediction;
        if (bus.pr_to_if_prediction) fetch_next = pc_q + imm_b;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_next_d = hold_next_q;
    iq_valid_d  = 1'b0;
    iq_inst_d   = iq_inst_q;
    iq_pc_d     = iq_pc_q;
    iq_pred_d   = iq_pred_q;
    if (bus.rob_to_if_flush) begin
      pc_d    = bus.rob_to_if_target;
      state_d = REDIRECT;
    end else begin
      case (state_q)
        REDIRECT: state_d = FETCH;
        FETCH: begin
          if (bus.mc_to_if_ready) begin
            // The IQ output registers double as the holding buffer while the queue is full.
            iq_inst_d = bus.mc_to_if_inst;
            iq_pc_d   = pc_q;
            iq_pred_d = fetch_pred;
            if (!bus.iq_full) begin
              iq_valid_d = 1'b1;
              pc_d       = fetch_next;
            end else begin
              hold_next_d = fetch_next;
              state_d     = HOLD;
            end
          end
        end
        HOLD: begin
          if (!bus.iq_full) begin
            iq_valid_d = 1'b1;
            pc_d       = hold_next_q;
            state_d    = FETCH;
          end
        end
        default: state_d = REDIRECT;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= REDIRECT;
      pc_q        <= RESET_PC;
      hold_next_q <= '0;
      iq_valid_q  <= 1'b0;
      iq_inst_q   <= '0;
      iq_pc_q     <= '0;
      iq_pred_q   <= 1'b0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_next_q <= hold_next_d;
      iq_valid_q  <= iq_valid_d;
      iq_inst_q   <= iq_inst_d;
      iq_pc_q     <= iq_pc_d;
      iq_pred_q   <= iq_pred_d;
    end
  end

  assign bus.if_to_mc_valid      = (state_q == FETCH);
  assign bus.if_to_mc_PC         = pc_q;
  assign bus.if_to_pr_PC         = pc_q;
  assign bus.if_to_iq_valid      = iq_valid_q;
  assign bus.if_to_iq_inst       = iq_inst_q;
  assign bus.if_to_iq_PC         = iq_pc_q;
  assign bus.if_to_iq_pred_taken = iq_pred_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic, checked every
// cycle against a transaction-level model of fetch/redirect/hold behaviour.
module tb_instr_fetch;
    localparam int AW = 32;
    localparam int IW = 32;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    always #5 clk_in = ~clk_in;

    instr_fetch_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

    instr_fetch #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .RESET_PC(32'h0)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
        logic [31:0] nxt;
    } ent_t;

    int total = 0;
    int bad   = 0;

    // Model: current fetch PC, pending redirect bubble, entry waiting for IQ space,
    // and the entry pushed on the most recent edge.
    logic [31:0] m_pc;
    bit          m_redir;
    ent_t        m_held[$];
    ent_t        m_out;
    bit          m_push;

    function automatic ent_t decode(logic [31:0] inst, logic [31:0] pc, logic p);
        ent_t e;
        logic [31:0] imm;
        e.inst = inst;
        e.pc   = pc;
        e.pred = 1'b0;
        e.nxt  = pc + 32'd4;
        if (inst[6:0] == 7'b1101111) begin
            imm    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            e.pred = 1'b1;
            e.nxt  = pc + imm;
        end else if (inst[6:0] == 7'b1100011) begin
            imm    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            e.pred = p;
            if (p) e.nxt = pc + imm;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        ent_t e;
        if (rst_in) begin
            m_pc    = 32'h0;
            m_redir = 1'b1;
            m_held.delete();
            m_push  = 1'b0;
            m_out   = '{inst: 32'h0, pc: 32'h0, pred: 1'b0, nxt: 32'h0};
        end else if (rdy_in) begin
            m_push = 1'b0;
            if (bus.rob_to_if_flush) begin
                m_pc    = bus.rob_to_if_target;
                m_redir = 1'b1;
                m_held.delete();
            end else if (m_redir) begin
                m_redir = 1'b0;
            end else if (m_held.size() != 0) begin
                if (!bus.iq_full) begin
                    m_out  = m_held.pop_front();
                    m_push = 1'b1;
                    m_pc   = m_out.nxt;
                end
            end else if (bus.mc_to_if_ready) begin
                e = decode(bus.mc_to_if_inst, m_pc, bus.pr_to_if_prediction);
                if (!bus.iq_full) begin
                    m_out  = e;
                    m_push = 1'b1;
                    m_pc   = e.nxt;
                end else begin
                    m_held.push_back(e);
                end
            end
        end
    endtask

    function automatic bit exp_mc_valid();
        return !m_redir && (m_held.size() == 0);
    endfunction

    task automatic compare_all();
        bit mv;
        mv = exp_mc_valid();
        chk1("mc_valid", bus.if_to_mc_valid, mv);
        if (mv) begin
            chk("mc_pc", bus.if_to_mc_PC, m_pc);
            chk("pr_pc", bus.if_to_pr_PC, m_pc);
        end
        chk1("iq_valid", bus.if_to_iq_valid, m_push);
        if (m_push || rst_in) begin
            chk("iq_inst", bus.if_to_iq_inst, m_out.inst);
            chk("iq_pc", bus.if_to_iq_PC, m_out.pc);
            chk1("iq_pred", bus.if_to_iq_pred_taken, m_out.pred);
        end
    endtask

    // One clock: model sees the inputs present at the edge, outputs are sampled 1ns later,
    // and single-cycle pulses are withdrawn afterwards.
    task automatic cyc();
        @(posedge clk_in);
        model_step();
        #1;
        compare_all();
        bus.mc_to_if_ready  = 1'b0;
        bus.rob_to_if_flush = 1'b0;
    endtask

    task automatic flush_to(input logic [31:0] t);
        bus.rob_to_if_flush  = 1'b1;
        bus.rob_to_if_target = t;
        cyc();
        cyc();
    endtask

    task automatic respond(input logic [31:0] inst, input logic p);
        bus.mc_to_if_ready      = 1'b1;
        bus.mc_to_if_inst       = inst;
        bus.pr_to_if_prediction = p;
        cyc();
    endtask

    initial begin
        logic [31:0] r;
        logic [6:0]  ops [5];
        ops[0] = 7'b1101111; ops[1] = 7'b1100011; ops[2] = 7'b1100111;
        ops[3] = 7'b0010011; ops[4] = 7'b0110011;

        rst_in = 1'b1;
        rdy_in = 1'b1;
        bus.pr_to_if_prediction = 1'b0;
        bus.mc_to_if_ready      = 1'b0;
        bus.mc_to_if_inst       = 32'h0;
        bus.iq_full             = 1'b0;
        bus.rob_to_if_flush     = 1'b0;
        bus.rob_to_if_target    = 32'h0;

        // Reset and first request
        cyc();
        cyc();
        chk1("rst_mc_valid", bus.if_to_mc_valid, 1'b0);
        chk1("rst_iq_valid", bus.if_to_iq_valid, 1'b0);
        rst_in = 1'b0;
        cyc();
        chk1("first_req_valid", bus.if_to_mc_valid, 1'b1);
        chk("first_req_pc", bus.if_to_mc_PC, 32'h0);

        // Plain ALU instruction
        respond(32'h00100093, 1'b0);
        chk1("addi_push", bus.if_to_iq_valid, 1'b1);
        chk("addi_inst", bus.if_to_iq_inst, 32'h00100093);
        chk("addi_pc", bus.if_to_iq_PC, 32'h0);
        chk1("addi_pred", bus.if_to_iq_pred_taken, 1'b0);
        chk("addi_next", bus.if_to_mc_PC, 32'h4);

        // Backward branch, predicted taken then not taken
        flush_to(32'h100);
        respond(32'hFE000CE3, 1'b1);
        chk1("beq_t_pred", bus.if_to_iq_pred_taken, 1'b1);
        chk("beq_t_next", bus.if_to_mc_PC, 32'hF8);
        flush_to(32'h100);
        respond(32'hFE000CE3, 1'b0);
        chk1("beq_nt_pred", bus.if_to_iq_pred_taken, 1'b0);
        chk("beq_nt_next", bus.if_to_mc_PC, 32'h104);

        // JAL is always taken regardless of the predictor
        flush_to(32'h200);
        respond(32'h0100006F, 1'b0);
        chk1("jal_pred", bus.if_to_iq_pred_taken, 1'b1);
        chk("jal_next", bus.if_to_mc_PC, 32'h210);

        // Queue full: hold three cycles, then one push
        bus.iq_full = 1'b1;
        respond(32'h00100093, 1'b0);
        for (int unsigned i = 0; i < 2; i++) cyc();
        chk1("hold_no_req", bus.if_to_mc_valid, 1'b0);
        chk1("hold_no_push", bus.if_to_iq_valid, 1'b0);
        bus.iq_full = 1'b0;
        cyc();
        chk1("hold_push", bus.if_to_iq_valid, 1'b1);
        chk("hold_push_pc", bus.if_to_iq_PC, 32'h210);
        chk("hold_resume", bus.if_to_mc_PC, 32'h214);
        cyc();
        chk1("hold_single_push", bus.if_to_iq_valid, 1'b0);

        // Flush coinciding with a ready is discarded
        flush_to(32'h8);
        bus.mc_to_if_ready   = 1'b1;
        bus.mc_to_if_inst    = 32'h00100093;
        bus.rob_to_if_flush  = 1'b1;
        bus.rob_to_if_target = 32'h400;
        cyc();
        chk1("flush_no_push", bus.if_to_iq_valid, 1'b0);
        chk1("flush_bubble", bus.if_to_mc_valid, 1'b0);
        cyc();
        chk("flush_target", bus.if_to_mc_PC, 32'h400);

        // Global stall freezes everything, even flush and ready
        respond(32'h00100093, 1'b0);
        rdy_in = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            bus.mc_to_if_ready   = 1'b1;
            bus.rob_to_if_flush  = 1'b1;
            bus.rob_to_if_target = 32'hDEAD0000;
            cyc();
        end
        chk1("stall_hold_push", bus.if_to_iq_valid, 1'b1);
        chk("stall_hold_pc", bus.if_to_mc_PC, 32'h404);
        rdy_in = 1'b1;
        cyc();
        chk1("stall_resume_push", bus.if_to_iq_valid, 1'b0);
        chk("stall_resume_pc", bus.if_to_mc_PC, 32'h404);

        // Back-to-back flushes: last target wins
        bus.rob_to_if_flush  = 1'b1;
        bus.rob_to_if_target = 32'h300;
        cyc();
        bus.rob_to_if_flush  = 1'b1;
        bus.rob_to_if_target = 32'h340;
        cyc();
        chk1("dflush_bubble", bus.if_to_mc_valid, 1'b0);
        cyc();
        chk("dflush_target", bus.if_to_mc_PC, 32'h340);

        // Reset takes effect while stalled
        rst_in = 1'b1;
        rdy_in = 1'b0;
        cyc();
        chk1("rst_over_rdy", bus.if_to_mc_valid, 1'b0);
        rst_in = 1'b0;
        rdy_in = 1'b1;
        cyc();

        // Random traffic
        for (int unsigned n = 0; n < 600; n++) begin
            rdy_in      = ($urandom_range(0, 9) != 0);
            bus.iq_full = ($urandom_range(0, 3) == 0);
            if ((exp_mc_valid() || m_redir) && $urandom_range(0, 9) < 4) begin
                r = $urandom();
                bus.mc_to_if_ready = 1'b1;
                bus.mc_to_if_inst  = {r[31:7], ops[$urandom_range(0, 4)]};
            end
            bus.pr_to_if_prediction = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 19) == 0) begin
                bus.rob_to_if_flush  = 1'b1;
                bus.rob_to_if_target = $urandom();
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch-side PC generator. It issues instruction fetch requests to the memory controller and queries the branch predictor for each returned instruction. It computes the next PC, pushes the instruction, PC and prediction bit into the instruction queue, and takes redirects from the ROB on misprediction flush. It is the querying end of the predictor lookup interface; the predictor answers combinationally.

Parameters:
ADDR_WIDTH, 32, width of all PC/address signals
INST_WIDTH, 32, instruction word width
RESET_PC, 32'h0, PC loaded on reset

Ports:
clk_in  input  1  clock, all state updates on rising edge
rst_in  input  1  synchronous reset, active-high
rdy_in  input  1  global ready; low freezes all state
if_to_pr_PC  output  ADDR_WIDTH  PC of instruction being fetched, for predictor lookup
pr_to_if_prediction  input  1  predicted-taken for if_to_pr_PC, combinational same cycle
if_to_mc_valid  output  1  fetch request
if_to_mc_PC  output  ADDR_WIDTH  fetch address
mc_to_if_ready  input  1  1-cycle pulse: mc_to_if_inst valid for the requested PC
mc_to_if_inst  input  INST_WIDTH  fetched instruction
iq_full  input  1  instruction queue cannot accept a push this cycle
if_to_iq_valid  output  1  push strobe, 1-cycle pulse
if_to_iq_inst  output  INST_WIDTH  pushed instruction
if_to_iq_PC  output  ADDR_WIDTH  PC of pushed instruction
if_to_iq_pred_taken  output  1  fetch predicted taken (branch/JAL)
rob_to_if_flush  input  1  misprediction redirect
rob_to_if_target  input  ADDR_WIDTH  redirect PC

Behaviour:
- Reset, while rst_in=1 at an edge: pc=RESET_PC, state=REDIRECT. if_to_mc_valid=0, if_to_iq_valid=0, if_to_iq_inst/PC/pred_taken=0. The first request appears the cycle after reset deasserts.
- rdy_in=0: no register changes, including flush handling. Registered outputs hold. rst_in overrides rdy_in.
- States: FETCH, HOLD, REDIRECT.
- REDIRECT: if_to_mc_valid=0 for exactly one cycle, so the memory controller abandons any outstanding fetch. Any mc_to_if_ready in this state is ignored. Next state is FETCH.
- FETCH: if_to_mc_valid=1, if_to_mc_PC=pc, if_to_pr_PC=pc (held stable the whole state). On mc_to_if_ready, next_pc is computed combinationally from mc_to_if_inst[6:0]:
  - 1101111 JAL: next=pc+immJ, pred=1.
  - 1100011 branch: pred=pr_to_if_prediction; next=pred ? pc+immB : pc+4.
  - 1100111 JALR and all others: next=pc+4, pred=0.
  - immB and immJ are sign-extended to ADDR_WIDTH; adds wrap modulo 2^ADDR_WIDTH; no alignment checks.
- On ready with iq_full=0: the next cycle has if_to_iq_valid=1 carrying inst, pc and pred. pc<=next_pc; stay FETCH. A new request to next_pc appears in that same next cycle.
- On ready with iq_full=1: latch inst, pc, pred and next_pc; go to HOLD.
- HOLD: if_to_mc_valid=0. When iq_full=0, push the latched entry (if_to_iq_valid=1 the next cycle), pc<=latched next_pc, go to FETCH.
- if_to_iq_valid is high for exactly one cycle per accepted instruction. No instruction is pushed twice or dropped, except on flush.
- Flush (rob_to_if_flush=1, rdy_in=1) has highest priority in every state. pc<=rob_to_if_target, state<=REDIRECT.
  - A held HOLD entry is discarded.
  - An mc_to_if_ready in the same cycle is discarded.
  - if_to_iq_valid=0 in the following cycle.
- Flush asserted on consecutive cycles: the last target wins, and REDIRECT is re-entered each cycle.
- Lookup index for the predictor is if_to_pr_PC[8:2]. The predicted-taken value is used only in the cycle mc_to_if_ready=1.

Test Plan:
1. Reset for 2 cycles, then release -> during reset if_to_mc_valid=0 and if_to_iq_valid=0; 1 cycle after release if_to_mc_valid=1 with if_to_mc_PC=0x0.
2. At PC 0x0, return 0x00100093 (addi) with iq_full=0 -> next cycle if_to_iq_valid=1, inst 0x00100093, PC 0x0, pred 0; if_to_mc_PC=0x4.
3. Flush to 0x100, then return 0xFE000CE3 (beq -8) with prediction=1 -> push pred 1, next if_to_mc_PC=0xF8. Rerun with prediction=0 -> pred 0, next PC 0x104.
4. Flush to 0x200, return 0x0100006F (jal +16) with prediction=0 -> pred 1, next if_to_mc_PC=0x210.
5. iq_full=1 when ready pulses -> if_to_mc_valid=0 for 3 held cycles, no push. Drop iq_full -> exactly one push 1 cycle later with the held data, then fetch resumes at next_pc.
6. Flush to 0x400 in the same cycle as ready at PC 0x8 -> no push; if_to_mc_valid=0 for one cycle, then if_to_mc_PC=0x400. Separately, rdy_in=0 for 4 cycles mid-FETCH -> all outputs frozen, resumes unchanged.
